// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master/slave cluster: slave addresses,
// byte-array type and the master/slave state encodings.
package i2c_pkg;

    localparam logic [6:0] SLAVE1_ADDR = 7'd84;
    localparam logic [6:0] SLAVE2_ADDR = 7'd86;
    localparam logic [6:0] SLAVE3_ADDR = 7'd87;
    localparam logic [6:0] SLAVE4_ADDR = 7'd88;

    localparam int MAX_BYTES = 10;

    typedef logic [MAX_BYTES-1:0][7:0] byte_arr_t;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, MACK, STOP
    } mstate_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_AACK, S_RX, S_WACK, S_TX, S_RACK, S_WAIT
    } sstate_t;

    // Requested byte count limited to the buffer depth.
    function automatic logic [3:0] clamp_count(input logic [9:0] n);
        return (n > 10'd10) ? 4'd10 : n[3:0];
    endfunction

endpackage

// File: rtl/i2c_slave.sv
// I2C slave at a fixed 7-bit address: stores written bytes, returns bytes
// from its read buffer, and resynchronises on every START/STOP.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR = SLAVE1_ADDR
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      scl,
    input  logic      sda,
    input  byte_arr_t data_in,
    output byte_arr_t data_out,
    output logic      sda_drv
);

    sstate_t     state, state_nxt;
    logic        scl_q, sda_q;
    logic [3:0]  bit_cnt, byte_cnt;
    logic [7:0]  sh;
    logic        rise, fall, start_c, stop_c;
    logic [7:0]  tx_byte;

    assign rise    = scl & ~scl_q;
    assign fall    = ~scl & scl_q;
    assign start_c = scl & scl_q & sda_q & ~sda;
    assign stop_c  = scl & scl_q & ~sda_q & sda;
    assign tx_byte = (byte_cnt < 4'(MAX_BYTES)) ? data_in[byte_cnt] : 8'hFF;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_c) begin
            state_nxt = S_ADDR;
        end else if (stop_c) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_ADDR:  if (fall && bit_cnt == 4'd8)
                             state_nxt = (sh[7:1] == ADDR) ? S_AACK : S_WAIT;
                S_AACK:  if (fall) state_nxt = sh[0] ? S_TX : S_RX;
                S_RX:    if (fall && bit_cnt == 4'd8) state_nxt = S_WACK;
                S_WACK:  if (fall) state_nxt = S_RX;
                S_TX:    if (fall && bit_cnt == 4'd8) state_nxt = S_RACK;
                S_RACK:  if (rise && sda) state_nxt = S_WAIT;
                         else if (fall && bit_cnt != 4'd0) state_nxt = S_TX;
                default: ;
            endcase
        end
    end

    always_comb begin
        sda_drv = 1'b1;
        case (state)
            S_AACK, S_WACK: sda_drv = 1'b0;
            S_TX:           sda_drv = sh[7];
            default:        ;
        endcase
    end

    // Bits are counted on SCL rise; SDA only moves on SCL fall so the
    // slave never creates a false START/STOP while SCL is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sh       <= '0;
            data_out <= '0;
        end else begin
            scl_q <= scl;
            sda_q <= sda;
            if (start_c) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else begin
                case (state)
                    S_ADDR, S_RX: begin
                        if (rise) begin
                            sh      <= {sh[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (state == S_RX && bit_cnt == 4'd7 && byte_cnt < 4'(MAX_BYTES))
                                data_out[byte_cnt] <= {sh[6:0], sda};
                        end
                        if (fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (state == S_RX) byte_cnt <= byte_cnt + 4'd1;
                        end
                    end
                    S_AACK: if (fall) begin
                        bit_cnt <= '0;
                        if (sh[0]) sh <= tx_byte;
                    end
                    S_TX: begin
                        if (rise) bit_cnt <= bit_cnt + 4'd1;
                        if (fall) begin
                            if (bit_cnt == 4'd8) begin
                                bit_cnt  <= '0;
                                byte_cnt <= byte_cnt + 4'd1;
                            end else begin
                                sh <= {sh[6:0], 1'b0};
                            end
                        end
                    end
                    S_RACK: begin
                        if (rise) bit_cnt <= 4'd1;
                        if (fall && bit_cnt != 4'd0) begin
                            bit_cnt <= '0;
                            sh      <= tx_byte;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/i2c_top.sv
// I2C master plus four fixed-address slaves on an internal wired-AND bus.
// SCL is generated from a phase counter; SDA moves mid-low, sampled mid-high.
module i2c_top
    import i2c_pkg::*;
#(
    parameter int SCL_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       read_write,
    input  logic [9:0] no_of_bytes,
    input  byte_arr_t  data_in,
    input  logic [6:0] slave_addr,
    input  byte_arr_t  data_in_1,
    input  byte_arr_t  data_in_2,
    input  byte_arr_t  data_in_3,
    input  byte_arr_t  data_in_4,
    output byte_arr_t  data_out,
    output byte_arr_t  data_out_1,
    output byte_arr_t  data_out_2,
    output byte_arr_t  data_out_3,
    output byte_arr_t  data_out_4,
    output logic       busy,
    output logic       ack_error
);

    localparam int HALF = SCL_DIV / 2;
    localparam int QTR  = HALF / 2;
    localparam int CW   = $clog2(SCL_DIV);
    localparam logic [CW-1:0] MID_LOW  = CW'(QTR);
    localparam logic [CW-1:0] MID_HIGH = CW'(HALF + QTR);
    localparam logic [CW-1:0] HALF_C   = CW'(HALF);
    localparam logic [CW-1:0] LAST     = CW'(SCL_DIV - 1);

    mstate_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [3:0] byte_idx, count;
    logic       rw, ack_bit, m_sda, m_scl;
    byte_arr_t  wbuf;
    logic [7:0] tx_sh, rx_sh;
    logic [3:0] s_sda;
    logic       sda, scl;
    logic       start_ok, bit_end, last_byte;

    assign sda       = m_sda & (&s_sda);
    assign scl       = m_scl;
    assign bit_end   = (cnt == LAST);
    assign last_byte = (byte_idx == count - 4'd1);
    assign start_ok  = en && !busy && (state == IDLE) && (no_of_bytes != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_ok) state_nxt = START;
            START:    if (bit_end) state_nxt = ADDR;
            ADDR:     if (bit_end && bit_idx == 3'd7) state_nxt = ADDR_ACK;
            ADDR_ACK: if (bit_end) state_nxt = ack_bit ? STOP : (rw ? RDATA : WDATA);
            WDATA:    if (bit_end && bit_idx == 3'd7) state_nxt = WACK;
            WACK:     if (bit_end) state_nxt = (ack_bit || last_byte) ? STOP : WDATA;
            RDATA:    if (bit_end && bit_idx == 3'd7) state_nxt = MACK;
            MACK:     if (bit_end) state_nxt = last_byte ? STOP : RDATA;
            STOP:     if (bit_end) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_scl = 1'b1;
        if (state != IDLE && state != START) m_scl = (cnt >= HALF_C);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            count     <= '0;
            rw        <= 1'b0;
            wbuf      <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            ack_bit   <= 1'b1;
            m_sda     <= 1'b1;
            busy      <= 1'b0;
            ack_error <= 1'b0;
            data_out  <= '0;
        end else if (start_ok) begin
            busy      <= 1'b1;
            ack_error <= 1'b0;
            count     <= clamp_count(no_of_bytes);
            rw        <= read_write;
            tx_sh     <= {slave_addr, read_write};
            wbuf      <= data_in;
            cnt       <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
        end else if (state != IDLE) begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (cnt == MID_LOW) begin
                case (state)
                    ADDR, WDATA: m_sda <= tx_sh[7];
                    MACK:        m_sda <= last_byte;
                    STOP:        m_sda <= 1'b0;
                    default:     m_sda <= 1'b1;
                endcase
            end
            // START/STOP conditions are the only SDA moves made while SCL is high.
            if (cnt == MID_HIGH) begin
                ack_bit <= sda;
                rx_sh   <= {rx_sh[6:0], sda};
                if (state == START) m_sda <= 1'b0;
                if (state == STOP)  m_sda <= 1'b1;
                if (state == RDATA && bit_idx == 3'd7)
                    data_out[byte_idx] <= {rx_sh[6:0], sda};
            end
            if (bit_end) begin
                case (state)
                    ADDR, WDATA, RDATA: begin
                        bit_idx <= bit_idx + 3'd1;
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                    end
                    ADDR_ACK: begin
                        if (ack_bit) ack_error <= 1'b1;
                        tx_sh <= wbuf[0];
                    end
                    WACK: begin
                        if (ack_bit) begin
                            ack_error <= 1'b1;
                        end else if (!last_byte) begin
                            byte_idx <= byte_idx + 4'd1;
                            tx_sh    <= wbuf[byte_idx + 4'd1];
                        end
                    end
                    MACK:    if (!last_byte) byte_idx <= byte_idx + 4'd1;
                    STOP:    busy <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    i2c_slave #(.ADDR(SLAVE1_ADDR)) u_slave1 (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda),
        .data_in(data_in_1), .data_out(data_out_1), .sda_drv(s_sda[0])
    );
    i2c_slave #(.ADDR(SLAVE2_ADDR)) u_slave2 (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda),
        .data_in(data_in_2), .data_out(data_out_2), .sda_drv(s_sda[1])
    );
    i2c_slave #(.ADDR(SLAVE3_ADDR)) u_slave3 (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda),
        .data_in(data_in_3), .data_out(data_out_3), .sda_drv(s_sda[2])
    );
    i2c_slave #(.ADDR(SLAVE4_ADDR)) u_slave4 (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda),
        .data_in(data_in_4), .data_out(data_out_4), .sda_drv(s_sda[3])
    );

endmodule

// File: tb/tb_i2c_top.sv
// Scoreboard bench for i2c_top: a byte-level model predicts every output
// buffer and ack_error per transaction; a monitor checks on busy falling.
module tb_i2c_top;
    import i2c_pkg::*;

    localparam int SCL_DIV = 8;

    logic       clk = 1'b0;
    logic       rst_n, en, read_write;
    logic [9:0] no_of_bytes;
    logic [6:0] slave_addr;
    byte_arr_t  data_in, data_out, do1, do2, do3, do4;
    byte_arr_t  din [1:4];
    logic       busy, ack_error;

    typedef struct {
        logic                   ack;
        logic [4:0][9:0][7:0]   mem;
        int unsigned            t0;
        int unsigned            bound;
    } exp_t;

    exp_t                 exp_q[$];
    exp_t                 mon_e;
    logic [4:0][9:0][7:0] mdl, mon_act;
    logic                 busy_q;
    int unsigned          cyc;
    int                   n_checks = 0;
    int                   n_fail = 0;

    i2c_top #(.SCL_DIV(SCL_DIV)) dut (
        .clk(clk), .reset(rst_n), .en(en), .read_write(read_write),
        .no_of_bytes(no_of_bytes), .data_in(data_in), .slave_addr(slave_addr),
        .data_in_1(din[1]), .data_in_2(din[2]), .data_in_3(din[3]), .data_in_4(din[4]),
        .data_out(data_out), .data_out_1(do1), .data_out_2(do2),
        .data_out_3(do3), .data_out_4(do4), .busy(busy), .ack_error(ack_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    function automatic int slave_idx(input logic [6:0] a);
        case (a)
            SLAVE1_ADDR: return 1;
            SLAVE2_ADDR: return 2;
            SLAVE3_ADDR: return 3;
            SLAVE4_ADDR: return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic byte_arr_t rand_bytes();
        byte_arr_t r;
        for (int k = 0; k < MAX_BYTES; k++) r[k] = 8'($urandom);
        return r;
    endfunction

    // Predicts the transaction outcome, then pulses en for one cycle.
    task automatic issue(input logic [6:0] a, input logic rw, input int n,
                         input byte_arr_t d, input bit push_exp);
        int   eff;
        int   idx;
        exp_t e;
        eff = (n == 0) ? 0 : ((n > MAX_BYTES) ? MAX_BYTES : n);
        idx = slave_idx(a);
        if (push_exp && eff > 0) begin
            e.ack = (idx == 0);
            if (idx != 0) begin
                for (int k = 0; k < eff; k++) begin
                    if (rw) mdl[0][k] = din[idx][k];
                    else    mdl[idx][k] = d[k];
                end
            end
            e.mem   = mdl;
            e.t0    = cyc;
            e.bound = ((idx == 0 ? 0 : eff) + 1) * 9 * SCL_DIV + 4 * SCL_DIV;
            exp_q.push_back(e);
        end
        slave_addr  = a;
        read_write  = rw;
        no_of_bytes = 10'(n);
        data_in     = d;
        en          = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_done(input int unsigned limit);
        int unsigned i = 0;
        while (busy && i < limit) begin
            @(negedge clk);
            i++;
        end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL completion_timeout: busy=1 after %0d cycles, expected 0", limit);
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            if (busy_q && !busy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_completion: busy fell, expected no transaction");
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_act[0] = data_out;
                    mon_act[1] = do1;
                    mon_act[2] = do2;
                    mon_act[3] = do3;
                    mon_act[4] = do4;
                    chk("ack_error", 80'(ack_error), 80'(mon_e.ack));
                    for (int i = 0; i < 5; i++)
                        chk((i == 0) ? "data_out" : $sformatf("data_out_%0d", i),
                            mon_act[i], mon_e.mem[i]);
                    n_checks++;
                    if (cyc - mon_e.t0 > mon_e.bound) begin
                        n_fail++;
                        $display("FAIL duration: got %0d cycles, expected <= %0d",
                                 cyc - mon_e.t0, mon_e.bound);
                    end
                end
            end
            busy_q <= busy;
        end
    end

    initial begin
        byte_arr_t   d;
        bit          quiet;
        logic [6:0]  a;
        int          n;
        rst_n = 1'b0; en = 1'b0; read_write = 1'b0; no_of_bytes = '0;
        slave_addr = '0; data_in = '0; mdl = '0; cyc = 0;
        for (int i = 1; i <= 4; i++) din[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 80'(busy), 80'(0));
        chk("reset_ack_error", 80'(ack_error), 80'(0));
        chk("reset_data_out", data_out, '0);
        chk("reset_data_out_1", do1, '0);
        chk("reset_data_out_4", do4, '0);
        chk("reset_bus", 80'({dut.sda, dut.scl}), 80'(2'b11));
        rst_n = 1'b1;
        @(negedge clk);

        d = '0; d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
        issue(SLAVE1_ADDR, 1'b0, 3, d, 1'b1);
        wait_done(1200);

        din[4][0] = 8'hA1; din[4][1] = 8'hB2; din[4][2] = 8'hC3; din[4][3] = 8'hD4;
        issue(SLAVE4_ADDR, 1'b1, 4, rand_bytes(), 1'b1);
        wait_done(1000);

        issue(7'd85, 1'b0, 2, rand_bytes(), 1'b1);
        wait_done(1200);

        // en while busy: the second pulse must leave no trace.
        issue(SLAVE3_ADDR, 1'b0, 5, rand_bytes(), 1'b1);
        repeat (60) @(negedge clk);
        issue(SLAVE1_ADDR, 1'b1, 2, rand_bytes(), 1'b0);
        wait_done(1200);
        repeat (20) @(negedge clk);
        chk("ignored_en_idle", 80'(busy), 80'(0));

        issue(SLAVE1_ADDR, 1'b0, 0, rand_bytes(), 1'b1);
        quiet = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (busy || !dut.sda || !dut.scl) quiet = 1'b0;
        end
        chk("zero_count_quiet", 80'(quiet), 80'(1));
        chk("zero_count_data_out_1", do1, mdl[1]);

        issue(SLAVE2_ADDR, 1'b0, 9, rand_bytes(), 1'b0);
        repeat (200) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        mdl = '0;
        @(negedge clk);
        chk("abort_busy", 80'(busy), 80'(0));
        chk("abort_data_out_2", do2, '0);
        chk("abort_bus", 80'({dut.sda, dut.scl}), 80'(2'b11));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(SLAVE2_ADDR, 1'b0, 9, rand_bytes(), 1'b1);
        wait_done(1200);

        for (int t = 0; t < 14; t++) begin
            for (int i = 1; i <= 4; i++) din[i] = rand_bytes();
            case ($urandom_range(0, 5))
                0:       a = SLAVE1_ADDR;
                1:       a = SLAVE2_ADDR;
                2:       a = SLAVE3_ADDR;
                3:       a = SLAVE4_ADDR;
                4:       a = 7'd85;
                default: a = 7'($urandom);
            endcase
            n = int'($urandom_range(0, 12));
            issue(a, 1'($urandom), n, rand_bytes(), 1'b1);
            if (n == 0) begin
                repeat (20) @(negedge clk);
                chk("rand_zero_count_busy", 80'(busy), 80'(0));
            end else begin
                wait_done(1200);
            end
        end

        repeat (10) @(negedge clk);
        chk("pending_expectations", 80'(exp_q.size()), 80'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
